pipe_protocol_checker: RTL and testbench

- Passive, synthesizable protocol monitor for the pipeline-to-memory request/response bus (the pipeconnect REQ/RES convention).
- Sits alongside any requester/cache pair and never drives the bus.
- Samples each request and response every clock and flags protocol violations through sticky flags, a pulse, a saturating counter and a captured address.

---
 rtl/pipe_protocol_checker.sv | 135 +++++++++++++
 tb/tb_pipe_protocol_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_protocol_checker.sv
// Passive REQ/RES bus monitor: sticky class flags, violation pulse, saturating count, last bad address; PIPECHECK_DISPLAY_EN adds sim messages.
// Latency: one cycle from the sampling edge to the registered error outputs.
// Backpressure: none; it only observes HOLD and never drives the bus.
module pipe_protocol_checker #(
  parameter     NAME     = "pipe",
  parameter int MAX_HOLD = 1024,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [69:0]      req,
  input  logic [32:0]      res,
  output logic             err_pulse,
  output logic [4:0]       err_flags,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      err_addr
);

  localparam logic [16:0] HOLD_LIM = 17'(MAX_HOLD);

  logic [31:0] a, p_a, wd, p_wd;
  logic        r, w, p_r, p_w, hold;
  logic [3:0]  wbe, p_wbe;
  logic [69:0] prev_req;
  logic        prev_hold;
  logic [16:0] hold_cnt;
  logic        wbe_legal, aligned, req_diff, both_idle;
  logic [4:0]  vec;

  assign a    = req[69:38];
  assign r    = req[37];
  assign w    = req[36];
  assign wd   = req[35:4];
  assign wbe  = req[3:0];
  assign hold = res[0];

  assign p_a   = prev_req[69:38];
  assign p_r   = prev_req[37];
  assign p_w   = prev_req[36];
  assign p_wd  = prev_req[35:4];
  assign p_wbe = prev_req[3:0];

  // Read data has no protocol rule attached to it.
  logic unused_rd;
  assign unused_rd = ^res[32:1];

  // WBE[3] addresses byte 0, so a single byte lane sits at 8 >> A[1:0].
  always_comb begin
    wbe_legal = 1'b0;
    aligned   = 1'b0;
    case (wbe)
      4'h8, 4'h4, 4'h2, 4'h1: begin
        wbe_legal = 1'b1;
        aligned   = (wbe == (4'h8 >> a[1:0]));
      end
      4'hC: begin
        wbe_legal = 1'b1;
        aligned   = ~a[1];
      end
      4'h3: begin
        wbe_legal = 1'b1;
        aligned   = a[1];
      end
      4'hF: begin
        wbe_legal = 1'b1;
        aligned   = (a[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Write payload only matters under hold when the held request was a write.
  assign req_diff  = (a != p_a) | (r != p_r) | (w != p_w) |
                     (p_w & ((wd != p_wd) | (wbe != p_wbe)));
  assign both_idle = ~r & ~w & ~p_r & ~p_w;

  assign vec[0] = r & w;
  assign vec[1] = w & ~wbe_legal;
  assign vec[2] = w & wbe_legal & ~aligned;
  assign vec[3] = prev_hold & req_diff & ~both_idle;
  assign vec[4] = hold & (hold_cnt == HOLD_LIM);

  // hold_cnt parks at MAX_HOLD+1 so a long episode times out only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_req  <= '0;
      prev_hold <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      prev_req  <= req;
      prev_hold <= hold;
      if (!hold)
        hold_cnt <= '0;
      else if (hold_cnt <= HOLD_LIM)
        hold_cnt <= hold_cnt + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_flags <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      err_pulse <= |vec;
      if (|vec) begin
        err_flags <= err_flags | vec;
        err_addr  <= a;
        if (err_count != {CNT_W{1'b1}})
          err_count <= err_count + CNT_W'(1);
      end
    end
  end

`ifdef PIPECHECK_DISPLAY_EN
  always @(posedge clk) begin
    if (rst_n && |vec) begin
      automatic string cls = "";
      if (vec[0]) cls = {cls, " RW_BOTH"};
      if (vec[1]) cls = {cls, " WBE_BAD"};
      if (vec[2]) cls = {cls, " MISALIGN"};
      if (vec[3]) cls = {cls, " HOLD_UNSTABLE"};
      if (vec[4]) cls = {cls, " HOLD_TIMEOUT"};
      $display("%0t %s:%s A=%h R=%b W=%b WD=%h WBE=%h HOLD=%b",
               $time, NAME, cls, a, r, w, wd, wbe, hold);
    end
  end

  final $display("%s: err_count=%0d", NAME, err_count);
`else
  localparam int unused_name_bits = $bits(NAME);
`endif

endmodule

// File: tb/tb_pipe_protocol_checker.sv
// Directed bench for pipe_protocol_checker with MAX_HOLD=4 and CNT_W=2.
module tb_pipe_protocol_checker;

  logic        clk;
  logic        rst_n;
  logic [69:0] req;
  logic [32:0] res;
  logic        err_pulse;
  logic [4:0]  err_flags;
  logic [1:0]  err_count;
  logic [31:0] err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_protocol_checker #(
    .NAME("dut"),
    .MAX_HOLD(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .res(res),
    .err_pulse(err_pulse),
    .err_flags(err_flags),
    .err_count(err_count),
    .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] mk(input logic [31:0] a, input logic r, input logic w,
                                     input logic [31:0] wd, input logic [3:0] wbe);
    return {a, r, w, wd, wbe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req   = '0;
    res   = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic       to_exp  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    req   = '0;
    res   = '0;
    tick();
    tick();
    chk("rst_pulse", 32'(err_pulse), 32'h0);
    chk("rst_flags", 32'(err_flags), 32'h0);
    chk("rst_count", 32'(err_count), 32'h0);
    chk("rst_addr",  err_addr,       32'h0);
    rst_n = 1'b1;

    // Legal traffic
    req = mk(32'h100, 1'b0, 1'b1, 32'hA5A5A5A5, 4'hF); tick();
    chk("legal_wF_pulse", 32'(err_pulse), 32'h0);
    req = mk(32'h103, 1'b0, 1'b1, 32'h000000EE, 4'h1); tick();
    chk("legal_w1_pulse", 32'(err_pulse), 32'h0);
    req = mk(32'h102, 1'b0, 1'b1, 32'h0000BEEF, 4'h3); tick();
    chk("legal_w3_pulse", 32'(err_pulse), 32'h0);
    req = mk(32'h101, 1'b1, 1'b0, 32'h0, 4'h0); tick();
    chk("legal_rd_pulse", 32'(err_pulse), 32'h0);
    chk("legal_flags",    32'(err_flags), 32'h0);
    chk("legal_count",    32'(err_count), 32'h0);

    // RW_BOTH, then flags retained with pulse dropping
    req = mk(32'h20, 1'b1, 1'b1, 32'h0, 4'hF); tick();
    chk("rw_pulse", 32'(err_pulse), 32'h1);
    chk("rw_flags", 32'(err_flags), 32'h01);
    chk("rw_count", 32'(err_count), 32'h1);
    chk("rw_addr",  err_addr,       32'h20);
    req = '0; tick();
    chk("rw_pulse_off", 32'(err_pulse), 32'h0);
    chk("rw_flags_kept", 32'(err_flags), 32'h01);
    chk("rw_count_kept", 32'(err_count), 32'h1);

    // Async reset between edges right after a violation
    req = mk(32'h24, 1'b1, 1'b1, 32'h0, 4'hF); tick();
    chk("rw2_pulse", 32'(err_pulse), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", 32'(err_pulse), 32'h0);
    chk("arst_flags", 32'(err_flags), 32'h0);
    chk("arst_count", 32'(err_count), 32'h0);
    chk("arst_addr",  err_addr,       32'h0);
    req   = '0;
    rst_n = 1'b1;

    // MISALIGN: full word at a half-word address
    req = mk(32'h102, 1'b0, 1'b1, 32'h0, 4'hF); tick();
    chk("mis_F_flags", 32'(err_flags), 32'h04);
    chk("mis_F_addr",  err_addr,       32'h102);
    pulse_reset();

    // MISALIGN: byte lane 8 belongs to A[1:0]=0, not 1
    req = mk(32'h101, 1'b0, 1'b1, 32'h0, 4'h8); tick();
    chk("mis_b_flags", 32'(err_flags), 32'h04);
    pulse_reset();

    // WBE_BAD only, not MISALIGN
    req = mk(32'h0, 1'b0, 1'b1, 32'h0, 4'h5); tick();
    chk("wbe_bad_flags", 32'(err_flags), 32'h02);
    chk("wbe_bad_count", 32'(err_count), 32'h1);
    pulse_reset();

    // RW_BOTH and WBE_BAD in the same cycle count once
    req = mk(32'h8, 1'b1, 1'b1, 32'h0, 4'h5); tick();
    chk("multi_flags", 32'(err_flags), 32'h03);
    chk("multi_count", 32'(err_count), 32'h1);
    chk("multi_addr",  err_addr,       32'h8);
    pulse_reset();

    // HOLD_UNSTABLE: write data changes while held
    req = mk(32'h40, 1'b0, 1'b1, 32'h11223344, 4'hF);
    res = {32'h0, 1'b1}; tick();
    chk("hu_first_pulse", 32'(err_pulse), 32'h0);
    req = mk(32'h40, 1'b0, 1'b1, 32'h0, 4'hF);
    res = {32'h0, 1'b0}; tick();
    chk("hu_flags", 32'(err_flags), 32'h08);
    chk("hu_pulse", 32'(err_pulse), 32'h1);
    chk("hu_addr",  err_addr,       32'h40);
    pulse_reset();

    // Only RD changes while held: legal
    req = mk(32'h40, 1'b0, 1'b1, 32'h11223344, 4'hF);
    res = {32'hDEAD0001, 1'b1}; tick();
    res = {32'h12345678, 1'b0}; tick();
    chk("rd_only_pulse", 32'(err_pulse), 32'h0);
    chk("rd_only_flags", 32'(err_flags), 32'h0);

    // Idle-to-idle with a changing address while held: legal
    req = mk(32'h5, 1'b0, 1'b0, 32'h0, 4'h0);
    res = {32'h0, 1'b1}; tick();
    req = mk(32'h6, 1'b0, 1'b0, 32'h0, 4'h0);
    res = {32'h0, 1'b0}; tick();
    chk("idle_flags", 32'(err_flags), 32'h0);
    pulse_reset();

    // HOLD_TIMEOUT: six held edges, fires on the fifth only
    for (int i = 0; i < 6; i++) begin
      res = {32'h0, 1'b1}; tick();
      chk($sformatf("to_pulse_%0d", i), 32'(err_pulse), 32'(to_exp[i]));
    end
    chk("to_flags", 32'(err_flags), 32'h10);
    chk("to_count", 32'(err_count), 32'h1);
    res = {32'h0, 1'b0}; tick();
    for (int i = 0; i < 5; i++) begin
      res = {32'h0, 1'b1}; tick();
      if (i == 3) chk("to2_count_before", 32'(err_count), 32'h1);
    end
    chk("to2_count", 32'(err_count), 32'h2);
    res = {32'h0, 1'b0}; tick();
    pulse_reset();

    // err_count saturates at 3 with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      req = mk(32'h20 + 32'(i), 1'b1, 1'b1, 32'h0, 4'hF); tick();
      chk($sformatf("sat_count_%0d", i), 32'(err_count), 32'(sat_exp[i]));
    end
    chk("sat_addr", err_addr, 32'h24);
    req = '0; tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
